// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the M:SS up-counting stopwatch.
//   BCD_BIT_WIDTH   width of one BCD digit
//   ST_*            2-bit control FSM state encodings
//   LIMIT*_DEFAULT  default maximum value of each digit (9:59 full scale)
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int BCD_BIT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_FULL  = 2'd3;

    localparam logic [BCD_BIT_WIDTH-1:0] LIMIT0_DEFAULT = 4'd9;
    localparam logic [BCD_BIT_WIDTH-1:0] LIMIT1_DEFAULT = 4'd5;
    localparam logic [BCD_BIT_WIDTH-1:0] LIMIT2_DEFAULT = 4'd9;

endpackage

// File: rtl/stopwatch_3d_if.sv
// -----------------------------------------------------------------------------
// stopwatch_3d_if
// Control and display bundle of the stopwatch.
//   tick        1-cycle count strobe (nominally 1 Hz)
//   start_stop  1-cycle pulse, start / pause toggle
//   clear       1-cycle pulse, back to 0:00 and IDLE
//   lap         1-cycle pulse, lap hold toggle (only with STOPWATCH_LAP_EN)
//   val0..val2  displayed BCD digits (seconds units, seconds tens, minutes)
//   running     high while counting
//   full        high once 9:59 has been reached
// Modports: master drives the controls (testbench / host), slave is the
// stopwatch itself.
// Optional feature macro: STOPWATCH_LAP_EN
// -----------------------------------------------------------------------------
interface stopwatch_3d_if;
    import stopwatch_pkg::*;

    logic                     tick;
    logic                     start_stop;
    logic                     clear;
`ifdef STOPWATCH_LAP_EN
    logic                     lap;
`endif
    logic [BCD_BIT_WIDTH-1:0] val0;
    logic [BCD_BIT_WIDTH-1:0] val1;
    logic [BCD_BIT_WIDTH-1:0] val2;
    logic                     running;
    logic                     full;

    modport master (
`ifdef STOPWATCH_LAP_EN
        output lap,
`endif
        output tick, start_stop, clear,
        input  val0, val1, val2, running, full
    );

    modport slave (
`ifdef STOPWATCH_LAP_EN
        input  lap,
`endif
        input  tick, start_stop, clear,
        output val0, val1, val2, running, full
    );

endinterface

// File: rtl/stopwatch_3d_upcounter.sv
// -----------------------------------------------------------------------------
// upcounter
// One BCD digit of the stopwatch carry chain.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_increase   advance the digit this cycle
//   i_clear      synchronous return to zero (wins over i_increase)
//   i_limit      largest value the digit holds before rolling to zero
//   o_value      registered digit value
//   o_carry      combinational: this digit rolls over on the current edge
// -----------------------------------------------------------------------------
module upcounter
    import stopwatch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_increase,
    input  logic                     i_clear,
    input  logic [BCD_BIT_WIDTH-1:0] i_limit,
    output logic [BCD_BIT_WIDTH-1:0] o_value,
    output logic                     o_carry
);

    logic [BCD_BIT_WIDTH-1:0] r_value;

    // Carry is combinational so the whole chain updates on a single edge.
    assign o_carry = i_increase && (r_value == i_limit);
    assign o_value = r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_clear) begin
            r_value <= '0;
        end else if (i_increase) begin
            r_value <= (r_value == i_limit) ? '0 : r_value + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_3d.sv
// -----------------------------------------------------------------------------
// stopwatch_3d
// Up-counting M:SS stopwatch, 0:00 -> 9:59 on a 1 Hz tick, saturating at
// full scale.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          stopwatch_3d_if.slave: tick/start_stop/clear(/lap) in,
//                val0/val1/val2/running/full out
// Parameters LIMIT0/1/2 give the largest value of each digit.
// Optional feature macro: STOPWATCH_LAP_EN adds the lap input and a lap hold
// register; with it undefined the display always shows the live count.
// -----------------------------------------------------------------------------
module stopwatch_3d
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_BIT_WIDTH-1:0] LIMIT0 = LIMIT0_DEFAULT,
    parameter logic [BCD_BIT_WIDTH-1:0] LIMIT1 = LIMIT1_DEFAULT,
    parameter logic [BCD_BIT_WIDTH-1:0] LIMIT2 = LIMIT2_DEFAULT
)
(
    input  logic          clk,
    input  logic          rst_n,
    stopwatch_3d_if.slave bus
);

    logic [1:0]               r_state;
    logic [1:0]               w_stateNext;
    logic                     w_inc0;
    logic                     w_carry0;
    logic                     w_carry1;
    logic                     w_carry2;
    logic                     w_reachFull;
    logic [BCD_BIT_WIDTH-1:0] w_live0;
    logic [BCD_BIT_WIDTH-1:0] w_live1;
    logic [BCD_BIT_WIDTH-1:0] w_live2;

    // Only a tick seen while already running advances the count, so a tick
    // arriving together with the start pulse is not counted.
    assign w_inc0 = (r_state == ST_RUN) && bus.tick;

    // This edge brings the count to full scale.
    assign w_reachFull = w_inc0
                      && (w_live0 == LIMIT0 - 4'd1)
                      && (w_live1 == LIMIT1)
                      && (w_live2 == LIMIT2);

    upcounter u_digit0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_increase (w_inc0),
        .i_clear    (bus.clear),
        .i_limit    (LIMIT0),
        .o_value    (w_live0),
        .o_carry    (w_carry0)
    );

    upcounter u_digit1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_increase (w_carry0),
        .i_clear    (bus.clear),
        .i_limit    (LIMIT1),
        .o_value    (w_live1),
        .o_carry    (w_carry1)
    );

    upcounter u_digit2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_increase (w_carry1),
        .i_clear    (bus.clear),
        .i_limit    (LIMIT2),
        .o_value    (w_live2),
        .o_carry    (w_carry2)
    );

    // Control FSM. clear beats everything; reaching full scale beats a
    // simultaneous pause request. A top-digit carry would mean a wrap, so it
    // also forces FULL as a guard.
    always_comb begin
        w_stateNext = r_state;
        if (bus.clear) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (bus.start_stop) w_stateNext = ST_RUN;
                ST_RUN: begin
                    if (w_reachFull || w_carry2) w_stateNext = ST_FULL;
                    else if (bus.start_stop)     w_stateNext = ST_PAUSE;
                end
                ST_PAUSE: if (bus.start_stop) w_stateNext = ST_RUN;
                default:  w_stateNext = ST_FULL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_stateNext;
    end

    assign bus.running = (r_state == ST_RUN);
    assign bus.full    = (r_state == ST_FULL);

`ifdef STOPWATCH_LAP_EN
    logic                         r_lapHold;
    logic [3*BCD_BIT_WIDTH-1:0]   r_lap;

    // Lap pulse toggles the hold outside IDLE; entering hold snapshots the
    // live count while the counters keep running underneath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lapHold <= 1'b0;
            r_lap     <= '0;
        end else if (bus.clear) begin
            r_lapHold <= 1'b0;
        end else if (bus.lap && (r_state != ST_IDLE)) begin
            r_lapHold <= !r_lapHold;
            if (!r_lapHold) r_lap <= {w_live2, w_live1, w_live0};
        end
    end

    assign bus.val0 = r_lapHold ? r_lap[3:0]  : w_live0;
    assign bus.val1 = r_lapHold ? r_lap[7:4]  : w_live1;
    assign bus.val2 = r_lapHold ? r_lap[11:8] : w_live2;
`else
    assign bus.val0 = w_live0;
    assign bus.val1 = w_live1;
    assign bus.val2 = w_live2;
`endif

endmodule

// File: tb/tb_stopwatch_3d.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_3d
// Self-checking bench for stopwatch_3d: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (carry ripple, saturation,
// asynchronous reset, simultaneous events, and lap hold when
// STOPWATCH_LAP_EN is defined).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_3d;
    import stopwatch_pkg::*;

    typedef struct {
        logic       tick;
        logic       ss;
        logic       clr;
        logic [3:0] e2;
        logic [3:0] e1;
        logic [3:0] e0;
        logic       eRun;
        logic       eFull;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;
    vec_t vecs[12];

    stopwatch_3d_if bus ();

    stopwatch_3d dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then sample 1 ns after
    // the following rising edge and drop the pulses again.
    task automatic applyStimulus(input logic t, input logic ss, input logic clr,
                                 input logic lp);
        @(negedge clk);
        bus.tick       = t;
        bus.start_stop = ss;
        bus.clear      = clr;
`ifdef STOPWATCH_LAP_EN
        bus.lap        = lp;
`else
        if (lp) $display("[TB] lap request ignored in this build");
`endif
        @(posedge clk);
        #1;
        bus.tick       = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        bus.lap        = 1'b0;
`endif
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e2,
                               input logic [3:0] e1, input logic [3:0] e0,
                               input logic eRun, input logic eFull);
        logic [13:0] act;
        logic [13:0] exp;
        act = {bus.val2, bus.val1, bus.val0, bus.running, bus.full};
        exp = {e2, e1, e0, eRun, eFull};
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h:%h%h run=%b full=%b, expected %h:%h%h run=%b full=%b",
                     name, bus.val2, bus.val1, bus.val0, bus.running, bus.full,
                     e2, e1, e0, eRun, eFull);
        end
    endtask

    initial begin
        testsRun       = 0;
        testsFailed    = 0;
        bus.tick       = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        bus.lap        = 1'b0;
`endif
        rst_n          = 1'b0;

        //            tick ss  clr  m     tens  units run full
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "start"};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, "tick1"};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, "tick2"};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, "ss+tick in run"};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, "tick in pause"};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, "resume"};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "clear+tick"};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "ss+tick in idle"};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, "tick after start"};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, "pause"};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, "ss+tick in pause"};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "clear"};

        #12;
        checkOutput("reset state", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].tick, vecs[i].ss, vecs[i].clr, 1'b0);
            checkOutput(vecs[i].name, vecs[i].e2, vecs[i].e1, vecs[i].e0,
                        vecs[i].eRun, vecs[i].eFull);
        end

        // Seconds roll into minutes on one edge.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(59);
        checkOutput("0:59", 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
        runTicks(1);
        checkOutput("carry to 1:00", 4'd1, 4'd0, 4'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle at 0:37.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(37);
        checkOutput("0:37 before reset", 4'd0, 4'd3, 4'd7, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation at 9:59.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(598);
        checkOutput("9:58", 4'd9, 4'd5, 4'd8, 1'b1, 1'b0);
        runTicks(1);
        checkOutput("full 9:59", 4'd9, 4'd5, 4'd9, 1'b0, 1'b1);
        runTicks(5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("full holds", 4'd9, 4'd5, 4'd9, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clear from full", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Final tick together with start_stop: full beats pause.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(598);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ss+final tick", 4'd9, 4'd5, 4'd9, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Pause with a simultaneous tick at 0:12.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(12);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("pause at 0:13", 4'd0, 4'd1, 4'd3, 1'b0, 1'b0);
        runTicks(1);
        checkOutput("paused 0:13", 4'd0, 4'd1, 4'd3, 1'b0, 1'b0);

        // Start with tick from IDLE, then clear + start_stop at 2:05.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("idle start+tick", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        runTicks(125);
        checkOutput("2:05", 4'd2, 4'd0, 4'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("clear+ss", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
        // Lap hold freezes the display while the count continues.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap in idle ignored", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runTicks(20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        runTicks(10);
        checkOutput("lap hold 0:20", 4'd0, 4'd2, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lap release 0:30", 4'd0, 4'd3, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runTicks(1);
        checkOutput("clear drops hold", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
